// File: rtl/qdec_cabac_package.sv
// Shared types and sizing for the CABAC bitstream fetch path.
// Holds the fetch FSM encoding and FIFO/length widths.
`timescale 1ns/1ps
package qdec_cabac_package;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FLUSH = 2'd3
   } bsf_state_e;

   localparam int BSF_FIFO_DEPTH = 4;
   localparam int BSF_LEN_W      = 24;
   localparam int BSF_WCNT_W     = BSF_LEN_W - 1;
   localparam int BSF_CNT_W      = $clog2(BSF_FIFO_DEPTH + 1);

   // Number of 32-bit words covering len bytes, rounded up.
   function automatic logic [BSF_WCNT_W-1:0] bsf_words(
      input logic [BSF_LEN_W-1:0] len
   );
      return {1'b0, len[BSF_LEN_W-1:2]}
           + {{(BSF_WCNT_W-1){1'b0}}, |len[1:0]};
   endfunction

endpackage

// File: rtl/qdec_sync_fifo.sv
// Single-clock FIFO with registered storage and occupancy count.
// Synchronous clear empties it without touching the reset.
`timescale 1ns/1ps
module qdec_sync_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= nxt(wr_ptr);
         end
         if (do_pop) rd_ptr <= nxt(rd_ptr);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/qdec_bs_fetch_ctrl.sv
// Bitstream fetch controller: reads job words from memory and
// streams them byte-wise (little-endian) to the CABAC decoder.
`timescale 1ns/1ps
module qdec_bs_fetch_ctrl
   import qdec_cabac_package::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_start,
   input  logic [31:0] cfg_base_addr,
   input  logic [23:0] cfg_byte_len,
   input  logic        abort,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_rvld,
   input  logic [31:0] mem_rdata,
   output logic [7:0]  bitstreamFetch,
   output logic        bitstreamFetch_vld,
   input  logic        bitstreamFetch_rdy,
   output logic        busy,
   output logic        done_pulse,
   output logic        err_pulse,
   output logic [23:0] bytes_sent
);

   bsf_state_e state_q;
   bsf_state_e state_d;

   logic [31:0]           addr_q;
   logic [BSF_WCNT_W-1:0] words_left_q;
   logic [BSF_LEN_W-1:0]  bytes_left_q;
   logic [BSF_LEN_W-1:0]  bytes_sent_q;
   logic [BSF_CNT_W-1:0]  outst_q;
   logic [1:0]            byte_idx_q;
   logic                  done_q;
   logic                  err_q;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_clr;
   logic                  fifo_empty;
   logic [31:0]           fifo_rdata;
   logic [BSF_CNT_W-1:0]  fifo_count;

   logic                  active;
   logic                  start_idle;
   logic                  start_ok;
   logic                  issue;
   logic                  ret;
   logic                  hs;
   logic                  last_byte;
   logic                  last_hs;
   logic                  credit_ok;
   logic [BSF_CNT_W:0]    credit_used;
   logic [7:0]            cur_byte;

   assign active     = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
   assign start_idle = cfg_start && (state_q == ST_IDLE);
   assign start_ok   = start_idle && (cfg_base_addr[1:0] == 2'b00)
                    && (cfg_byte_len != '0);
   assign issue      = mem_req && mem_gnt;
   assign ret        = mem_rvld && (outst_q != '0);
   assign hs         = bitstreamFetch_vld && bitstreamFetch_rdy;
   assign last_byte  = (bytes_left_q == BSF_LEN_W'(1));
   assign last_hs    = hs && last_byte;

   // A slot is reserved at issue time so the FIFO can never overflow.
   assign credit_used = {1'b0, outst_q} + {1'b0, fifo_count};
   assign credit_ok   = credit_used < (BSF_CNT_W+1)'(BSF_FIFO_DEPTH);

   assign fifo_push = active && ret;
   assign fifo_pop  = hs && ((byte_idx_q == 2'd3) || last_byte);
   assign fifo_clr  = (state_q == ST_FLUSH);

   qdec_sync_fifo #(
      .WIDTH (32),
      .DEPTH (BSF_FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (fifo_clr),
      .push  (fifo_push),
      .wdata (mem_rdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Abort takes priority over completing the job.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (abort)
               state_d = ST_FLUSH;
            else if (issue && words_left_q == BSF_WCNT_W'(1))
               state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (abort)        state_d = ST_FLUSH;
            else if (last_hs) state_d = ST_IDLE;
         end
         ST_FLUSH: begin
            if (outst_q == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req            = 1'b0;
      bitstreamFetch_vld = 1'b0;
      busy               = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            mem_req            = (words_left_q != '0) && credit_ok;
            bitstreamFetch_vld = !fifo_empty;
            busy               = 1'b1;
         end
         ST_DRAIN: begin
            bitstreamFetch_vld = !fifo_empty;
            busy               = 1'b1;
         end
         ST_FLUSH: busy = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      cur_byte = '0;
      unique case (byte_idx_q)
         2'd0: cur_byte = fifo_rdata[7:0];
         2'd1: cur_byte = fifo_rdata[15:8];
         2'd2: cur_byte = fifo_rdata[23:16];
         2'd3: cur_byte = fifo_rdata[31:24];
         default: cur_byte = '0;
      endcase
   end

   assign bitstreamFetch = bitstreamFetch_vld ? cur_byte : 8'h00;
   assign mem_addr       = addr_q;
   assign done_pulse     = done_q;
   assign err_pulse      = err_q;
   assign bytes_sent     = bytes_sent_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         words_left_q <= '0;
         bytes_left_q <= '0;
         bytes_sent_q <= '0;
         outst_q      <= '0;
         byte_idx_q   <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         outst_q <= outst_q + BSF_CNT_W'(issue) - BSF_CNT_W'(ret);
         if (start_idle) begin
            bytes_sent_q <= '0;
            if (cfg_base_addr[1:0] != 2'b00) err_q  <= 1'b1;
            else if (cfg_byte_len == '0)     done_q <= 1'b1;
         end
         if (start_ok) begin
            addr_q       <= cfg_base_addr;
            words_left_q <= bsf_words(cfg_byte_len);
            bytes_left_q <= cfg_byte_len;
            byte_idx_q   <= '0;
         end
         if (issue) begin
            addr_q       <= addr_q + 32'd4;
            words_left_q <= words_left_q - BSF_WCNT_W'(1);
         end
         if (hs) begin
            bytes_sent_q <= bytes_sent_q + BSF_LEN_W'(1);
            bytes_left_q <= bytes_left_q - BSF_LEN_W'(1);
            byte_idx_q   <= fifo_pop ? 2'd0 : byte_idx_q + 2'd1;
         end
         if (active && abort) err_q <= 1'b1;
         if (state_q == ST_DRAIN && last_hs && !abort) done_q <= 1'b1;
         if (state_q == ST_FLUSH) byte_idx_q <= '0;
      end
   end

endmodule

// File: tb/tb_qdec_bs_fetch_ctrl.sv
// Directed bench for qdec_bs_fetch_ctrl with a latency-configurable
// in-order memory responder and a negedge byte/grant monitor.
`timescale 1ns/1ps
module tb_qdec_bs_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0;
   logic [31:0] cfg_base_addr = '0;
   logic [23:0] cfg_byte_len = '0;
   logic        abort = 1'b0;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_gnt = 1'b1;
   logic        mem_rvld;
   logic [31:0] mem_rdata;
   logic [7:0]  bitstreamFetch;
   logic        bitstreamFetch_vld;
   logic        bitstreamFetch_rdy = 1'b1;
   logic        busy;
   logic        done_pulse;
   logic        err_pulse;
   logic [23:0] bytes_sent;

   int checks = 0;
   int passed = 0;
   int cyc = 0;
   int mem_lat = 1;
   int rvld_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   int          due_q[$];
   logic [31:0] dat_q[$];
   logic [31:0] addr_log[$];
   logic [7:0]  rx[$];

   qdec_bs_fetch_ctrl dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cfg_start          (cfg_start),
      .cfg_base_addr      (cfg_base_addr),
      .cfg_byte_len       (cfg_byte_len),
      .abort              (abort),
      .mem_req            (mem_req),
      .mem_addr           (mem_addr),
      .mem_gnt            (mem_gnt),
      .mem_rvld           (mem_rvld),
      .mem_rdata          (mem_rdata),
      .bitstreamFetch     (bitstreamFetch),
      .bitstreamFetch_vld (bitstreamFetch_vld),
      .bitstreamFetch_rdy (bitstreamFetch_rdy),
      .busy               (busy),
      .done_pulse         (done_pulse),
      .err_pulse          (err_pulse),
      .bytes_sent         (bytes_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] exp_byte(input logic [31:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {exp_byte(a + 32'd3), exp_byte(a + 32'd2),
              exp_byte(a + 32'd1), exp_byte(a)};
   endfunction

   // Events seen here take effect at the following rising edge.
   always @(negedge clk) begin
      if (due_q.size() != 0 && due_q[0] <= cyc) begin
         mem_rvld  <= 1'b1;
         mem_rdata <= dat_q[0];
         void'(due_q.pop_front());
         void'(dat_q.pop_front());
         rvld_cnt  <= rvld_cnt + 1;
      end else begin
         mem_rvld  <= 1'b0;
         mem_rdata <= '0;
      end
      if (rst_n && mem_req && mem_gnt) begin
         due_q.push_back(cyc + mem_lat);
         dat_q.push_back(mem_word(mem_addr));
         addr_log.push_back(mem_addr);
      end
      if (rst_n && bitstreamFetch_vld && bitstreamFetch_rdy)
         rx.push_back(bitstreamFetch);
      if (done_pulse) done_cnt <= done_cnt + 1;
      if (err_pulse)  err_cnt  <= err_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [31:0] b, input logic [23:0] l);
      cfg_base_addr = b;
      cfg_byte_len  = l;
      cfg_start     = 1'b1;
      tick();
      cfg_start     = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!busy) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if ({mem_req, mem_addr, bitstreamFetch, bitstreamFetch_vld, busy,
           done_pulse, err_pulse, bytes_sent} !== '0)
         $display("FAIL reset_outputs: req=%b addr=%h vld=%b busy=%b sent=%0d want all 0",
                  mem_req, mem_addr, bitstreamFetch_vld, busy, bytes_sent);
      else passed++;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int a0, r0, d0, bad;
      bit to;
      logic [7:0] eb [10];
      eb = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E,
             8'h5F, 8'h5C, 8'h5D, 8'h52, 8'h53};
      a0 = addr_log.size(); r0 = rx.size(); d0 = done_cnt;
      mem_lat = 1; mem_gnt = 1'b0; bitstreamFetch_rdy = 1'b1;
      start_job(32'h0000_1000, 24'd10);
      tick();
      tick();
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h0000_1000})
         $display("FAIL basic_req_hold: req=%b addr=%h want 1 00001000",
                  mem_req, mem_addr);
      else passed++;
      mem_gnt = 1'b1;
      wait_idle(100, to);
      tick();
      tick();
      checks++;
      if (to !== 1'b0) $display("FAIL basic_timeout: busy stuck got %b want 0", busy);
      else passed++;
      bad = 0;
      if (addr_log.size() - a0 != 3) bad = 1;
      else if (addr_log[a0] !== 32'h1000 || addr_log[a0+1] !== 32'h1004 ||
               addr_log[a0+2] !== 32'h1008) bad = 1;
      checks++;
      if (bad != 0) $display("FAIL basic_addrs: got %0d reads want 3 at 1000/1004/1008",
                             addr_log.size() - a0);
      else passed++;
      bad = 0;
      if (rx.size() - r0 != 10) bad = 1;
      else for (int i = 0; i < 10; i++) if (rx[r0+i] !== eb[i]) bad++;
      checks++;
      if (bad != 0) $display("FAIL basic_bytes: got %0d bytes, %0d wrong, want 10 LE bytes",
                             rx.size() - r0, bad);
      else passed++;
      checks++;
      if (done_cnt - d0 != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
      else passed++;
      checks++;
      if (bytes_sent !== 24'd10) $display("FAIL basic_sent: got %0d want 10", bytes_sent);
      else passed++;
   endtask

   task automatic test_backpressure();
      int a0, r0, d0, c, maxc, bad;
      bit to;
      a0 = addr_log.size(); r0 = rx.size(); d0 = done_cnt;
      maxc = 0;
      mem_lat = 6; bitstreamFetch_rdy = 1'b0;
      start_job(32'h0000_2000, 24'd64);
      for (int i = 0; i < 50; i++) begin
         tick();
         c = (addr_log.size() - a0) - (rx.size() - r0) / 4;
         if (c > maxc) maxc = c;
      end
      checks++;
      if (addr_log.size() - a0 != 4)
         $display("FAIL bp_stall_reads: got %0d want 4", addr_log.size() - a0);
      else passed++;
      checks++;
      if ({bitstreamFetch_vld, bitstreamFetch} !== {1'b1, 8'h5A})
         $display("FAIL bp_vld_hold: vld=%b byte=%h want 1 5a",
                  bitstreamFetch_vld, bitstreamFetch);
      else passed++;
      bitstreamFetch_rdy = 1'b1;
      to = 1'b1;
      for (int i = 0; i < 400; i++) begin
         tick();
         c = (addr_log.size() - a0) - (rx.size() - r0) / 4;
         if (c > maxc) maxc = c;
         if (!busy) begin
            to = 1'b0;
            break;
         end
      end
      tick();
      tick();
      checks++;
      if (to !== 1'b0 || maxc > 4)
         $display("FAIL bp_credits: timeout=%b max=%0d want 0 and <=4", to, maxc);
      else passed++;
      bad = 0;
      if (rx.size() - r0 != 64) bad = 1;
      else for (int i = 0; i < 64; i++)
         if (rx[r0+i] !== exp_byte(32'h2000 + i)) bad++;
      checks++;
      if (bad != 0) $display("FAIL bp_bytes: got %0d bytes, %0d wrong, want 64",
                             rx.size() - r0, bad);
      else passed++;
      checks++;
      if (addr_log.size() - a0 != 16 || done_cnt - d0 != 1)
         $display("FAIL bp_done: reads=%0d done=%0d want 16 1",
                  addr_log.size() - a0, done_cnt - d0);
      else passed++;
      checks++;
      if (bytes_sent !== 24'd64) $display("FAIL bp_sent: got %0d want 64", bytes_sent);
      else passed++;
   endtask

   task automatic test_errors();
      int a0, d0, e0;
      a0 = addr_log.size(); d0 = done_cnt; e0 = err_cnt;
      mem_lat = 1;
      start_job(32'h0000_1002, 24'd8);
      checks++;
      if ({err_pulse, busy, mem_req} !== 3'b100)
         $display("FAIL misalign_err: err=%b busy=%b req=%b want 1 0 0",
                  err_pulse, busy, mem_req);
      else passed++;
      repeat (4) tick();
      checks++;
      if (err_cnt - e0 != 1 || addr_log.size() != a0 || busy !== 1'b0)
         $display("FAIL misalign_quiet: errs=%0d reads=%0d busy=%b want 1 0 0",
                  err_cnt - e0, addr_log.size() - a0, busy);
      else passed++;
      start_job(32'h0000_3000, 24'd0);
      checks++;
      if ({done_pulse, busy, mem_req} !== 3'b100)
         $display("FAIL zero_len_done: done=%b busy=%b req=%b want 1 0 0",
                  done_pulse, busy, mem_req);
      else passed++;
      repeat (4) tick();
      checks++;
      if (done_cnt - d0 != 1 || addr_log.size() != a0 || err_cnt - e0 != 1)
         $display("FAIL zero_len_quiet: done=%0d reads=%0d errs=%0d want 1 0 1",
                  done_cnt - d0, addr_log.size() - a0, err_cnt - e0);
      else passed++;
   endtask

   task automatic test_abort();
      int r0, d0, e0, rv0, bad;
      bit to;
      r0 = rx.size(); d0 = done_cnt; e0 = err_cnt;
      mem_lat = 2; mem_gnt = 1'b0; bitstreamFetch_rdy = 1'b0;
      start_job(32'h0000_4000, 24'd32);
      mem_gnt = 1'b1;
      tick();
      tick();
      mem_gnt = 1'b0;
      bitstreamFetch_rdy = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (rx.size() - r0 >= 5) break;
      end
      bitstreamFetch_rdy = 1'b0;
      mem_lat = 10;
      mem_gnt = 1'b1;
      tick();
      tick();
      mem_gnt = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      rv0 = rvld_cnt;
      bitstreamFetch_rdy = 1'b1;
      checks++;
      if ({bitstreamFetch_vld, err_pulse, busy} !== 3'b011)
         $display("FAIL abort_entry: vld=%b err=%b busy=%b want 0 1 1",
                  bitstreamFetch_vld, err_pulse, busy);
      else passed++;
      wait_idle(60, to);
      checks++;
      if (to !== 1'b0 || rvld_cnt - rv0 != 2)
         $display("FAIL abort_flush_exit: timeout=%b rvld=%0d want 0 2",
                  to, rvld_cnt - rv0);
      else passed++;
      tick();
      tick();
      checks++;
      if (err_cnt - e0 != 1 || done_cnt - d0 != 0)
         $display("FAIL abort_pulses: err=%0d done=%0d want 1 0",
                  err_cnt - e0, done_cnt - d0);
      else passed++;
      bad = 0;
      if (rx.size() - r0 != 5) bad = 1;
      else for (int i = 0; i < 5; i++)
         if (rx[r0+i] !== exp_byte(32'h4000 + i)) bad++;
      checks++;
      if (bad != 0) $display("FAIL abort_bytes: got %0d bytes, %0d wrong, want 5",
                             rx.size() - r0, bad);
      else passed++;
      checks++;
      if (bytes_sent !== 24'd5) $display("FAIL abort_sent: got %0d want 5", bytes_sent);
      else passed++;
      mem_gnt = 1'b1;
   endtask

   task automatic test_wrap();
      int a0, d0;
      bit to;
      a0 = addr_log.size(); d0 = done_cnt;
      mem_lat = 1; mem_gnt = 1'b1; bitstreamFetch_rdy = 1'b1;
      start_job(32'hFFFF_FFF8, 24'd12);
      wait_idle(100, to);
      tick();
      tick();
      checks++;
      if (addr_log.size() - a0 != 3 ||
          addr_log[a0] !== 32'hFFFF_FFF8 ||
          addr_log[a0+1] !== 32'hFFFF_FFFC ||
          addr_log[a0+2] !== 32'h0000_0000)
         $display("FAIL wrap_addrs: got %0d reads want FFFFFFF8 FFFFFFFC 00000000",
                  addr_log.size() - a0);
      else passed++;
      checks++;
      if (to !== 1'b0 || bytes_sent !== 24'd12 || done_cnt - d0 != 1)
         $display("FAIL wrap_done: timeout=%b sent=%0d done=%0d want 0 12 1",
                  to, bytes_sent, done_cnt - d0);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int r0, d0, bad;
      bit to;
      logic [7:0] eb [6];
      eb = '{8'h5A, 8'h5B, 8'h58, 8'h59, 8'h5E, 8'h5F};
      mem_lat = 8; bitstreamFetch_rdy = 1'b1;
      start_job(32'h0000_5000, 24'd16);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({mem_req, mem_addr, bitstreamFetch, bitstreamFetch_vld, busy,
           done_pulse, err_pulse, bytes_sent} !== '0)
         $display("FAIL midreset_outputs: req=%b addr=%h busy=%b sent=%0d want all 0",
                  mem_req, mem_addr, busy, bytes_sent);
      else passed++;
      tick();
      tick();
      rst_n = 1'b1;
      r0 = rx.size();
      for (int i = 0; i < 40; i++) begin
         tick();
         if (due_q.size() == 0 && i > 12) break;
      end
      checks++;
      if (rx.size() != r0 || busy !== 1'b0)
         $display("FAIL midreset_late_rvld: bytes=%0d busy=%b want 0 0",
                  rx.size() - r0, busy);
      else passed++;
      d0 = done_cnt;
      mem_lat = 1;
      start_job(32'h0000_6000, 24'd6);
      wait_idle(100, to);
      tick();
      tick();
      checks++;
      if (to !== 1'b0 || done_cnt - d0 != 1 || bytes_sent !== 24'd6)
         $display("FAIL midreset_newjob: timeout=%b done=%0d sent=%0d want 0 1 6",
                  to, done_cnt - d0, bytes_sent);
      else passed++;
      bad = 0;
      if (rx.size() - r0 != 6) bad = 1;
      else for (int i = 0; i < 6; i++) if (rx[r0+i] !== eb[i]) bad++;
      checks++;
      if (bad != 0) $display("FAIL midreset_bytes: got %0d bytes, %0d wrong, want 6",
                             rx.size() - r0, bad);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_errors();
      test_abort();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached, checks=%0d", checks);
      $fatal(1);
   end

endmodule
